// File: rtl/instr_decoder_if.sv
// Fetch-to-decode bundle: instruction in, registered decode results out.
// The fetch side uses master; the decoder uses slave.
interface instr_decoder_if #(parameter int XLEN = 32);
  logic [XLEN-1:0] instr;
  logic            instr_valid;
  logic            out_valid;
  logic            ALUreg;
  logic            ALUimm;
  logic            Load;
  logic            Store;
  logic            Branch;
  logic            JAL;
  logic            JALR;
  logic            LUI;
  logic            AUIPC;
  logic            regWrite;
  logic            illegal;
  logic [4:0]      rd;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm;

  modport master (
    output instr, instr_valid,
    input  out_valid, ALUreg, ALUimm, Load, Store, Branch, JAL, JALR, LUI, AUIPC,
           regWrite, illegal, rd, rs1, rs2, funct3, funct7, imm
  );

  modport slave (
    input  instr, instr_valid,
    output out_valid, ALUreg, ALUimm, Load, Store, Branch, JAL, JALR, LUI, AUIPC,
           regWrite, illegal, rd, rs1, rs2, funct3, funct7, imm
  );
endinterface

// File: rtl/instr_decoder.sv
// Registered RV32I base-opcode decoder: one instruction per cycle, 1-cycle latency.
// Class flags drop on idle cycles; field and immediate registers hold.
module instr_decoder #(
  parameter int XLEN = 32
) (
  input logic           clk,
  input logic           rst_n,
  instr_decoder_if.slave dec
);

  localparam logic [6:0] OP_ALUREG = 7'b0110011;
  localparam logic [6:0] OP_ALUIMM = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  logic [XLEN-1:0] i;
  logic            alureg_d, aluimm_d, load_d, store_d, branch_d;
  logic            jal_d, jalr_d, lui_d, auipc_d, regwrite_d, illegal_d;
  logic [XLEN-1:0] imm_d;

  assign i = dec.instr;

  always_comb begin
    alureg_d  = 1'b0;
    aluimm_d  = 1'b0;
    load_d    = 1'b0;
    store_d   = 1'b0;
    branch_d  = 1'b0;
    jal_d     = 1'b0;
    jalr_d    = 1'b0;
    lui_d     = 1'b0;
    auipc_d   = 1'b0;
    illegal_d = 1'b0;
    imm_d     = '0;
    case (i[6:0])
      OP_ALUREG: alureg_d = 1'b1;
      OP_ALUIMM: begin
        aluimm_d = 1'b1;
        imm_d    = {{20{i[31]}}, i[31:20]};
      end
      OP_LOAD: begin
        load_d = 1'b1;
        imm_d  = {{20{i[31]}}, i[31:20]};
      end
      OP_JALR: begin
        jalr_d = 1'b1;
        imm_d  = {{20{i[31]}}, i[31:20]};
      end
      OP_STORE: begin
        store_d = 1'b1;
        imm_d   = {{20{i[31]}}, i[31:25], i[11:7]};
      end
      OP_BRANCH: begin
        branch_d = 1'b1;
        imm_d    = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      end
      OP_LUI: begin
        lui_d = 1'b1;
        imm_d = {i[31:12], 12'b0};
      end
      OP_AUIPC: begin
        auipc_d = 1'b1;
        imm_d   = {i[31:12], 12'b0};
      end
      OP_JAL: begin
        jal_d = 1'b1;
        imm_d = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      end
      default: illegal_d = 1'b1;
    endcase
    // Writes rd regardless of rd==x0; the register file discards x0 writes.
    regwrite_d = alureg_d | aluimm_d | load_d | jal_d | jalr_d | lui_d | auipc_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec.out_valid <= 1'b0;
      dec.ALUreg    <= 1'b0;
      dec.ALUimm    <= 1'b0;
      dec.Load      <= 1'b0;
      dec.Store     <= 1'b0;
      dec.Branch    <= 1'b0;
      dec.JAL       <= 1'b0;
      dec.JALR      <= 1'b0;
      dec.LUI       <= 1'b0;
      dec.AUIPC     <= 1'b0;
      dec.regWrite  <= 1'b0;
      dec.illegal   <= 1'b0;
      dec.rd        <= '0;
      dec.rs1       <= '0;
      dec.rs2       <= '0;
      dec.funct3    <= '0;
      dec.funct7    <= '0;
      dec.imm       <= '0;
    end else begin
      dec.out_valid <= dec.instr_valid;
      dec.ALUreg    <= dec.instr_valid & alureg_d;
      dec.ALUimm    <= dec.instr_valid & aluimm_d;
      dec.Load      <= dec.instr_valid & load_d;
      dec.Store     <= dec.instr_valid & store_d;
      dec.Branch    <= dec.instr_valid & branch_d;
      dec.JAL       <= dec.instr_valid & jal_d;
      dec.JALR      <= dec.instr_valid & jalr_d;
      dec.LUI       <= dec.instr_valid & lui_d;
      dec.AUIPC     <= dec.instr_valid & auipc_d;
      dec.regWrite  <= dec.instr_valid & regwrite_d;
      dec.illegal   <= dec.instr_valid & illegal_d;
      if (dec.instr_valid) begin
        dec.rd     <= i[11:7];
        dec.rs1    <= i[19:15];
        dec.rs2    <= i[24:20];
        dec.funct3 <= i[14:12];
        dec.funct7 <= i[31:25];
        dec.imm    <= imm_d;
      end
    end
  end

endmodule

// File: tb/tb_instr_decoder.sv
// Directed bench for instr_decoder: hand-decoded RV32I words, checked 1 cycle
// after presentation, plus idle-hold and asynchronous reset behaviour.
module tb_instr_decoder;

  logic clk;
  logic rst_n;
  int   passed;
  int   total;

  instr_decoder_if #(.XLEN(32)) dif ();

  instr_decoder #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .dec   (dif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {out_valid, ALUreg, ALUimm, Load, Store, Branch, JAL, JALR, LUI, AUIPC, regWrite, illegal}
  localparam logic [11:0] F_OV     = 12'h800;
  localparam logic [11:0] F_ALUREG = 12'h400;
  localparam logic [11:0] F_ALUIMM = 12'h200;
  localparam logic [11:0] F_LOAD   = 12'h100;
  localparam logic [11:0] F_STORE  = 12'h080;
  localparam logic [11:0] F_BRANCH = 12'h040;
  localparam logic [11:0] F_JAL    = 12'h020;
  localparam logic [11:0] F_JALR   = 12'h010;
  localparam logic [11:0] F_LUI    = 12'h008;
  localparam logic [11:0] F_AUIPC  = 12'h004;
  localparam logic [11:0] F_RW     = 12'h002;
  localparam logic [11:0] F_ILL    = 12'h001;

  function automatic logic [11:0] flags();
    return {dif.out_valid, dif.ALUreg, dif.ALUimm, dif.Load, dif.Store, dif.Branch,
            dif.JAL, dif.JALR, dif.LUI, dif.AUIPC, dif.regWrite, dif.illegal};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step(input logic [31:0] word, input logic valid);
    dif.instr       = word;
    dif.instr_valid = valid;
    @(posedge clk);
    #1;
  endtask

  initial begin
    passed          = 0;
    total           = 0;
    rst_n           = 1'b0;
    dif.instr       = 32'h002081B3;
    dif.instr_valid = 1'b1;

    // 1. Reset holds everything at zero despite a valid instruction.
    repeat (2) @(posedge clk);
    #1;
    check("rst_flags", {20'h0, flags()}, 32'h0);
    check("rst_fields", {7'h0, dif.funct7, dif.rs2, dif.rs1, dif.funct3, dif.rd}, 32'h0);
    check("rst_imm", dif.imm, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step(32'h002081B3, 1'b1);
    check("add_flags", {20'h0, flags()}, {20'h0, F_OV | F_ALUREG | F_RW});
    check("add_rd", {27'h0, dif.rd}, 32'd3);
    check("add_rs1", {27'h0, dif.rs1}, 32'd1);
    check("add_rs2", {27'h0, dif.rs2}, 32'd2);
    check("add_imm", dif.imm, 32'h0);

    // 2. Back-to-back ALU / memory instructions.
    step(32'h00508193, 1'b1);
    check("addi_flags", {20'h0, flags()}, {20'h0, F_OV | F_ALUIMM | F_RW});
    check("addi_imm", dif.imm, 32'd5);
    step(32'h0040A183, 1'b1);
    check("lw_flags", {20'h0, flags()}, {20'h0, F_OV | F_LOAD | F_RW});
    check("lw_funct3", {29'h0, dif.funct3}, 32'd2);
    check("lw_imm", dif.imm, 32'd4);
    step(32'h0030A223, 1'b1);
    check("sw_flags", {20'h0, flags()}, {20'h0, F_OV | F_STORE});
    check("sw_imm", dif.imm, 32'd4);
    check("sw_rs2", {27'h0, dif.rs2}, 32'd3);

    // 3. Control flow.
    step(32'h00308163, 1'b1);
    check("beq_flags", {20'h0, flags()}, {20'h0, F_OV | F_BRANCH});
    check("beq_imm", dif.imm, 32'd2);
    step(32'h004081E7, 1'b1);
    check("jalr_flags", {20'h0, flags()}, {20'h0, F_OV | F_JALR | F_RW});
    check("jalr_imm", dif.imm, 32'd4);
    step(32'h000001EF, 1'b1);
    check("jal_flags", {20'h0, flags()}, {20'h0, F_OV | F_JAL | F_RW});
    check("jal_imm", dif.imm, 32'h0);
    // jal x1,-2048: imm bits scattered across J-format
    step(32'h801FF0EF, 1'b1);
    check("jal_neg_imm", dif.imm, 32'hFFF00000 | 32'h000FF800);

    // 4. Upper immediates and sign extension.
    step(32'h000011B7, 1'b1);
    check("lui_flags", {20'h0, flags()}, {20'h0, F_OV | F_LUI | F_RW});
    check("lui_imm", dif.imm, 32'h00001000);
    step(32'h00001197, 1'b1);
    check("auipc_flags", {20'h0, flags()}, {20'h0, F_OV | F_AUIPC | F_RW});
    check("auipc_imm", dif.imm, 32'h00001000);
    step(32'hFFF00093, 1'b1);
    check("addi_neg_imm", dif.imm, 32'hFFFFFFFF);
    check("addi_x0_rd", {27'h0, dif.rd}, 32'd1);
    step(32'hFE009EE3, 1'b1);
    check("bne_flags", {20'h0, flags()}, {20'h0, F_OV | F_BRANCH});
    check("bne_imm", dif.imm, 32'hFFFFFFFC);
    check("bne_funct3", {29'h0, dif.funct3}, 32'd1);
    check("bne_funct7", {25'h0, dif.funct7}, 32'h7F);

    // Idle after bne: flags drop, fields and imm hold.
    step(32'h00000000, 1'b0);
    check("idle1_flags", {20'h0, flags()}, 32'h0);
    check("idle1_imm", dif.imm, 32'hFFFFFFFC);
    check("idle1_funct7", {25'h0, dif.funct7}, 32'h7F);

    // 5. Illegal opcodes, including non-32-bit encodings.
    step(32'h0000000F, 1'b1);
    check("fence_flags", {20'h0, flags()}, {20'h0, F_OV | F_ILL});
    check("fence_imm", dif.imm, 32'h0);
    step(32'h00000073, 1'b1);
    check("ecall_flags", {20'h0, flags()}, {20'h0, F_OV | F_ILL});
    step(32'h00508192, 1'b1);
    check("short_flags", {20'h0, flags()}, {20'h0, F_OV | F_ILL});
    check("short_rd", {27'h0, dif.rd}, 32'd3);
    step(32'h00000000, 1'b0);
    check("idle2_flags", {20'h0, flags()}, 32'h0);
    check("idle2_rd", {27'h0, dif.rd}, 32'd3);
    check("idle2_imm", dif.imm, 32'h0);

    // 6. Asynchronous reset mid-stream, no clock edge in between.
    step(32'h00508193, 1'b1);
    check("pre_rst_flags", {20'h0, flags()}, {20'h0, F_OV | F_ALUIMM | F_RW});
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_flags", {20'h0, flags()}, 32'h0);
    check("async_rst_imm", dif.imm, 32'h0);
    check("async_rst_rd", {27'h0, dif.rd}, 32'h0);
    @(negedge clk);
    rst_n           = 1'b1;
    dif.instr       = 32'h000011B7;
    dif.instr_valid = 1'b1;
    #1;
    check("post_rst_before_edge", {20'h0, flags()}, 32'h0);
    @(posedge clk);
    #1;
    check("post_rst_lui_flags", {20'h0, flags()}, {20'h0, F_OV | F_LUI | F_RW});
    check("post_rst_lui_imm", dif.imm, 32'h00001000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
